mem_access_unit: RTL

CPU-side bus initiator for the memory controller. It accepts one load/store request at a time from the core and checks alignment. It drives the controller's read/write strobes, address and write data, and performs read-modify-write for byte and halfword stores. It extracts and sign- or zero-extends load data, bounds bus stalls with a timeout, and returns one response per request.

---
 rtl/mem_access_unit.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : CPU-side bus initiator for the memory controller. Accepts one
//            load/store at a time, rejects misaligned/illegal requests,
//            performs read-modify-write for byte/halfword stores, extracts
//            and extends load data, bounds bus stalls with a timeout and
//            returns exactly one response per accepted request.
// Ports    : clk, rst            - clock, async active-high reset
//            req_*               - request handshake and fields from the core
//            resp_*              - one-cycle response pulse (no backpressure)
//            mem_read/mem_write  - strobes to the controller
//            mem_addr/mem_wdata  - word address and write word
//            mem_rdata           - read word from the controller
//            mem_error/mem_busy  - controller error and stall
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_error,
  input  logic        mem_busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_READ  = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  localparam logic [1:0] C_SZ_BYTE = 2'b00;
  localparam logic [1:0] C_SZ_HALF = 2'b01;
  localparam logic [1:0] C_SZ_WORD = 2'b10;
  // Wait counter value on the last (sampling) cycle of a read phase.
  localparam logic [2:0] C_WAIT_LAST = 3'(WAIT_CYCLES);
  // Timeout counter value at which one more busy cycle hits TIMEOUT.
  localparam logic [7:0] C_TMO_LAST  = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic        r_write;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_wait;
  logic [7:0]  r_tmo;

  logic        w_bad;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merged;
  logic        w_tmo_hit;

  assign w_bad = (r_size == 2'b11) ||
                 ((r_size == C_SZ_HALF) && r_addr[0]) ||
                 ((r_size == C_SZ_WORD) && (r_addr[1:0] != 2'b00));

  // Little-endian lane extraction from the word currently on the bus.
  assign w_byte = mem_rdata[{r_addr[1:0], 3'b000} +: 8];
  assign w_half = mem_rdata[{r_addr[1], 4'b0000} +: 16];

  assign w_tmo_hit = (r_tmo == C_TMO_LAST);

  always_comb begin
    w_load = mem_rdata;
    case (r_size)
      C_SZ_BYTE: w_load = {{24{r_signed & w_byte[7]}}, w_byte};
      C_SZ_HALF: w_load = {{16{r_signed & w_half[15]}}, w_half};
      default:   w_load = mem_rdata;
    endcase
  end

  // Sub-word store data dropped into the sampled word; other lanes kept.
  always_comb begin
    w_merged = mem_rdata;
    if (r_size == C_SZ_BYTE) begin
      w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    end else begin
      w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_write    <= 1'b0;
      r_size     <= 2'b00;
      r_signed   <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_wait     <= 3'd0;
      r_tmo      <= 8'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_error <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write   <= req_write;
            r_size    <= req_size;
            r_signed  <= req_signed;
            r_addr    <= req_addr;
            r_wdata   <= req_wdata;
            req_ready <= 1'b0;
            r_state   <= S_CHECK;
          end
        end

        S_CHECK: begin
          r_wait <= 3'd0;
          r_tmo  <= 8'd0;
          if (w_bad) begin
            resp_valid <= 1'b1;
            resp_error <= 1'b1;
            resp_rdata <= 32'd0;
            r_state    <= S_RESP;
          end else if (r_write && (r_size == C_SZ_WORD)) begin
            mem_addr  <= {r_addr[31:2], 2'b00};
            mem_wdata <= r_wdata;
            mem_write <= 1'b1;
            r_state   <= S_WRITE;
          end else begin
            mem_addr <= {r_addr[31:2], 2'b00};
            mem_read <= 1'b1;
            r_state  <= S_READ;
          end
        end

        S_READ: begin
          // Errors and timeouts share one exit; a read error on an RMW
          // never reaches the write phase.
          if (mem_error || (mem_busy && w_tmo_hit)) begin
            mem_read   <= 1'b0;
            resp_valid <= 1'b1;
            resp_error <= 1'b1;
            resp_rdata <= 32'd0;
            r_state    <= S_RESP;
          end else if (mem_busy) begin
            r_tmo <= r_tmo + 8'd1;
          end else if (r_wait == C_WAIT_LAST) begin
            mem_read <= 1'b0;
            if (r_write) begin
              mem_wdata <= w_merged;
              mem_write <= 1'b1;
              r_tmo     <= 8'd0;
              r_state   <= S_WRITE;
            end else begin
              resp_valid <= 1'b1;
              resp_error <= 1'b0;
              resp_rdata <= w_load;
              r_state    <= S_RESP;
            end
          end else begin
            r_wait <= r_wait + 3'd1;
          end
        end

        S_WRITE: begin
          if (mem_error || (mem_busy && w_tmo_hit)) begin
            mem_write  <= 1'b0;
            resp_valid <= 1'b1;
            resp_error <= 1'b1;
            resp_rdata <= 32'd0;
            r_state    <= S_RESP;
          end else if (mem_busy) begin
            r_tmo <= r_tmo + 8'd1;
          end else begin
            mem_write  <= 1'b0;
            resp_valid <= 1'b1;
            resp_error <= 1'b0;
            resp_rdata <= 32'd0;
            r_state    <= S_RESP;
          end
        end

        S_RESP: begin
          resp_valid <= 1'b0;
          resp_error <= 1'b0;
          resp_rdata <= 32'd0;
          req_ready  <= 1'b1;
          r_state    <= S_IDLE;
        end

        default: begin
          mem_read   <= 1'b0;
          mem_write  <= 1'b0;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
